// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus decode handoff.
// master = fetch stage, slave = memory/decode side.
interface instruction_fetch_if;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic [1:0]  o_instr_fault;
  logic        i_instr_ready;
  logic [31:0] o_fetch_count;

  modport master (
    output o_mem_req,
    output o_mem_addr,
    input  i_mem_ready,
    input  i_mem_rvalid,
    input  i_mem_rdata,
    input  i_mem_err,
    output o_instr_valid,
    output o_instr,
    output o_instr_pc,
    output o_instr_fault,
    input  i_instr_ready,
    output o_fetch_count
  );

  modport slave (
    input  o_mem_req,
    input  o_mem_addr,
    output i_mem_ready,
    output i_mem_rvalid,
    output i_mem_rdata,
    output i_mem_err,
    input  o_instr_valid,
    input  o_instr,
    input  o_instr_pc,
    input  o_instr_fault,
    output i_instr_ready,
    input  o_fetch_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single outstanding word read, buffered result,
// flush/redirect, misalignment check and response watchdog.
module instruction_fetch #(
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [31:0]         i_pc,
  input  logic                i_fetch_en,
  input  logic                i_flush,
  instruction_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_BUS = 2'b10;
  localparam logic [1:0] F_TMO = 2'b11;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic       TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic        req_q;
  logic        valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (i_fetch_en && !i_flush) begin
          pc_d = i_pc;
          if (i_pc[1:0] != 2'b00) begin
            state_d = HOLD;
            instr_d = NOP_INSTR;
            fault_d = F_MIS;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_flush) begin
          state_d = bus.i_mem_ready ? DRAIN : IDLE;
          pend_d  = 1'b0;
        end else if (bus.i_mem_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        if (i_flush) begin
          state_d = bus.i_mem_rvalid ? IDLE : DRAIN;
          pend_d  = 1'b0;
        end else if (bus.i_mem_rvalid) begin
          state_d = HOLD;
          instr_d = bus.i_mem_rdata;
          fault_d = bus.i_mem_err ? F_BUS : F_OK;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (TMO_EN && (tmo_d == TMO_LIMIT)) begin
            state_d = DRAIN;
            pend_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        // response still owed by memory; swallow it before going idle
        if (i_flush) begin
          pend_d = 1'b0;
          if (bus.i_mem_rvalid) state_d = IDLE;
        end else if (bus.i_mem_rvalid) begin
          pend_d = 1'b0;
          if (pend_q) begin
            state_d = HOLD;
            instr_d = NOP_INSTR;
            fault_d = F_TMO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (i_flush) begin
          state_d = IDLE;
        end else if (bus.i_instr_ready) begin
          state_d = IDLE;
          count_d = count_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      fault_q <= F_OK;
      tmo_q   <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == HOLD);
    end
  end

  assign bus.o_mem_req     = req_q;
  assign bus.o_mem_addr    = pc_q;
  assign bus.o_instr_valid = valid_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_pc    = pc_q;
  assign bus.o_instr_fault = fault_q;
  assign bus.o_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for the basic flow,
// hand sequences for flush, timeout, bus error and reset corners.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc  = '0;
  logic        fe  = 1'b0;
  logic        fl  = 1'b0;

  instruction_fetch_if bus();

  instruction_fetch #(
    .NOP_INSTR(32'h0000_0013),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_pc      (pc),
    .i_fetch_en(fe),
    .i_flush   (fl),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = '0;

  typedef struct {
    logic [31:0] pc;
    logic        fe, fl, rdy, rv;
    logic [31:0] rdata;
    logic        err, ir;
    logic        req, vld;
    logic [31:0] instr, ipc;
    logic [1:0]  flt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] p, input logic f, input logic flu,
                     input logic r, input logic v, input logic [31:0] d,
                     input logic e, input logic ir);
    pc                = p;
    fe                = f;
    fl                = flu;
    bus.i_mem_ready   = r;
    bus.i_mem_rvalid  = v;
    bus.i_mem_rdata   = d;
    bus.i_mem_err     = e;
    bus.i_instr_ready = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_ctl(input string nm, input logic req,
                         input logic vld);
    chk({nm, ".req"}, {31'b0, bus.o_mem_req}, {31'b0, req});
    chk({nm, ".vld"}, {31'b0, bus.o_instr_valid}, {31'b0, vld});
  endtask

  task automatic chk_dat(input string nm, input logic [31:0] ins,
                         input logic [31:0] ipc, input logic [1:0] flt);
    chk({nm, ".vld"}, {31'b0, bus.o_instr_valid}, 32'd1);
    chk({nm, ".instr"}, bus.o_instr, ins);
    chk({nm, ".pc"}, bus.o_instr_pc, ipc);
    chk({nm, ".fault"}, {30'b0, bus.o_instr_fault}, {30'b0, flt});
  endtask

  task automatic handshake(input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    exp_cnt++;
    chk({nm, ".vld"}, {31'b0, bus.o_instr_valid}, 32'd0);
    chk({nm, ".cnt"}, bus.o_fetch_count, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h100, 1, 0, 0, 0, 32'h0, 0, 0,
                1, 0, 32'h0, 32'h0, 2'b00, 32'd0};
    tbl[1]  = '{32'h0, 0, 0, 1, 0, 32'h0, 0, 0,
                0, 0, 32'h0, 32'h0, 2'b00, 32'd0};
    tbl[2]  = '{32'h0, 0, 0, 0, 1, 32'h00500093, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[3]  = '{32'h0, 0, 0, 0, 0, 32'h0, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[4]  = '{32'h300, 1, 0, 0, 0, 32'h0, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[5]  = '{32'h0, 0, 0, 0, 1, 32'h11111111, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[6]  = '{32'h0, 0, 0, 1, 0, 32'h0, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[7]  = '{32'h0, 0, 0, 0, 0, 32'h0, 0, 0,
                0, 1, 32'h00500093, 32'h100, 2'b00, 32'd0};
    tbl[8]  = '{32'h0, 0, 0, 0, 0, 32'h0, 0, 1,
                0, 0, 32'h0, 32'h0, 2'b00, 32'd1};
    tbl[9]  = '{32'h0, 0, 0, 0, 0, 32'h0, 0, 0,
                0, 0, 32'h0, 32'h0, 2'b00, 32'd1};
    tbl[10] = '{32'h102, 1, 0, 0, 0, 32'h0, 0, 0,
                0, 1, 32'h13, 32'h102, 2'b01, 32'd1};
    tbl[11] = '{32'h0, 0, 0, 0, 0, 32'h0, 0, 1,
                0, 0, 32'h0, 32'h0, 2'b00, 32'd2};

    // reset state
    rst = 1'b1;
    idle(2);
    chk_ctl("rst", 0, 0);
    chk("rst.cnt", bus.o_fetch_count, 32'd0);
    chk("rst.instr", bus.o_instr, 32'd0);
    chk("rst.fault", {30'b0, bus.o_instr_fault}, 32'd0);
    chk("rst.addr", bus.o_mem_addr, 32'd0);
    rst = 1'b0;

    // basic fetch, back-pressure, misaligned
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].pc, tbl[i].fe, tbl[i].fl, tbl[i].rdy, tbl[i].rv,
          tbl[i].rdata, tbl[i].err, tbl[i].ir);
      chk_ctl($sformatf("v%0d", i), tbl[i].req, tbl[i].vld);
      chk($sformatf("v%0d.cnt", i), bus.o_fetch_count, tbl[i].cnt);
      if (tbl[i].req)
        chk($sformatf("v%0d.addr", i), bus.o_mem_addr, tbl[i].pc);
      if (tbl[i].vld)
        chk_dat($sformatf("v%0d", i), tbl[i].instr, tbl[i].ipc, tbl[i].flt);
    end
    exp_cnt = 32'd2;

    // flush in WAIT, late data discarded, then clean refetch
    cyc(32'h180, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("fw.req", 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk_ctl("fw.flush", 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    chk_ctl("fw.late", 0, 0);
    idle(1);
    chk_ctl("fw.idle", 0, 0);
    cyc(32'h200, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("fw.re", 1, 0);
    chk("fw.addr", bus.o_mem_addr, 32'h200);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h00A00113, 0, 0);
    chk_dat("fw.data", 32'h00A00113, 32'h200, 2'b00);
    handshake("fw.hs");

    // flush in REQ withdraws request; stray rvalid in IDLE ignored
    cyc(32'h240, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("fr.req", 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk_ctl("fr.flush", 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h55555555, 0, 0);
    chk_ctl("fr.stray", 0, 0);

    // flush beats a same-cycle handshake in HOLD
    cyc(32'h241, 1, 0, 0, 0, 0, 0, 0);
    chk_dat("fh.mis", 32'h13, 32'h241, 2'b01);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    chk_ctl("fh.flush", 0, 0);
    chk("fh.cnt", bus.o_fetch_count, exp_cnt);

    // flush together with ready in REQ must drain the response
    cyc(32'h280, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0BAD0BAD, 0, 0);
    chk_ctl("fd.drain", 0, 0);
    idle(1);
    chk_ctl("fd.idle", 0, 0);

    // response on the last WAIT cycle still delivers data
    cyc(32'h400, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    idle(3);
    chk_ctl("tb.wait", 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h00100073, 0, 0);
    chk_dat("tb.data", 32'h00100073, 32'h400, 2'b00);
    handshake("tb.hs");

    // watchdog expiry, late response presents timeout fault
    cyc(32'h404, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk_ctl("to.drain", 0, 0);
    idle(2);
    chk_ctl("to.drain2", 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    chk_dat("to.fault", 32'h13, 32'h404, 2'b11);
    handshake("to.hs");

    // bus error
    cyc(32'h500, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hCAFEBABE, 1, 0);
    chk_dat("be", 32'hCAFEBABE, 32'h500, 2'b10);
    handshake("be.hs");

    // flush in DRAIN cancels pending timeout fault
    cyc(32'h600, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h77777777, 0, 0);
    chk_ctl("tc.rv", 0, 0);
    idle(1);
    chk_ctl("tc.idle", 0, 0);

    // reset in REQ
    cyc(32'h700, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("rr.req", 1, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_cnt = '0;
    chk_ctl("rr", 0, 0);
    chk("rr.cnt", bus.o_fetch_count, 32'd0);

    // reset in HOLD
    cyc(32'h704, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h00000033, 0, 0);
    handshake("rh.pre");
    cyc(32'h703, 1, 0, 0, 0, 0, 0, 0);
    chk_dat("rh.mis", 32'h13, 32'h703, 2'b01);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_cnt = '0;
    chk_ctl("rh", 0, 0);
    chk("rh.cnt", bus.o_fetch_count, 32'd0);

    // normal operation after reset
    cyc(32'h800, 1, 0, 0, 0, 0, 0, 0);
    chk_ctl("pr.req", 1, 0);
    chk("pr.addr", bus.o_mem_addr, 32'h800);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h00000073, 0, 0);
    chk_dat("pr", 32'h00000073, 32'h800, 2'b00);
    handshake("pr.hs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
